// File: rtl/step_clock_gen.sv
// Tempo generator: turns a clamped BPM into step strobe, 50% step level, step index and bar strobe.
// Latency: first step_pulse 34 clks after play is sampled high; later pulses every NUM/bpm_c clks.
// Backpressure: none; outputs free-run while play=1, play=0 returns to IDLE on the next clk.
module step_clock_gen #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS_PER_BEAT = 4,
    parameter int STEPS_PER_BAR  = 16,
    parameter int BPM_MIN        = 40,
    parameter int BPM_MAX        = 240,
    parameter int PERIOD_W       = 32
) (
    input  logic                             clk,
    input  logic                             nReset,
    input  logic                             play,
    input  logic [7:0]                       bpm,
    output logic                             step_pulse,
    output logic                             step_level,
    output logic [$clog2(STEPS_PER_BAR)-1:0] step_idx,
    output logic                             bar_pulse,
    output logic                             busy
);
    localparam int IDX_W = $clog2(STEPS_PER_BAR);
    localparam int IT_W  = $clog2(PERIOD_W + 1);
    localparam logic [63:0] NUM64 = (64'(CLK_HZ) * 64'd60) / 64'(STEPS_PER_BEAT);
    localparam logic [PERIOD_W-1:0] NUM = NUM64[PERIOD_W-1:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]          state;
    logic [7:0]          bpm_c;
    logic [7:0]          bpm_l;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] next_period;
    logic [PERIOD_W-1:0] quo;
    logic [PERIOD_W-1:0] rem;
    logic [PERIOD_W-1:0] dvs;
    logic [IT_W-1:0]     it;
    logic                pend;
    logic                first;
    logic [PERIOD_W:0]   shifted;
    logic [PERIOD_W:0]   trial;
    logic [IDX_W-1:0]    idx_next;
    logic                restart;
    logic                div_done;
    logic                wrap;

    always_comb begin
        bpm_c = bpm;
        if (bpm < 8'(BPM_MIN)) begin
            bpm_c = 8'(BPM_MIN);
        end else if (bpm > 8'(BPM_MAX)) begin
            bpm_c = 8'(BPM_MAX);
        end
    end

    // Restoring division: remainder stays below the divisor, so the borrow bit is the sign.
    assign shifted  = {rem, quo[PERIOD_W-1]};
    assign trial    = shifted - {1'b0, dvs};
    assign restart  = (bpm_c != bpm_l);
    assign div_done = (it == IT_W'(PERIOD_W));
    assign wrap     = (cnt == period - PERIOD_W'(1));
    assign idx_next = first ? '0 : step_idx + 1'b1;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            step_pulse  <= 1'b0;
            step_level  <= 1'b0;
            step_idx    <= '0;
            bar_pulse   <= 1'b0;
            busy        <= 1'b0;
            period      <= '0;
            cnt         <= '0;
            next_period <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            it          <= '0;
            bpm_l       <= '0;
            pend        <= 1'b0;
            first       <= 1'b0;
        end else if (!play) begin
            state      <= IDLE;
            step_pulse <= 1'b0;
            step_level <= 1'b0;
            step_idx   <= '0;
            bar_pulse  <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            it         <= '0;
            pend       <= 1'b0;
            first      <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            bar_pulse  <= 1'b0;
            case (state)
                IDLE: state <= CALC;
                CALC: begin
                    if (busy && div_done && !restart) begin
                        period <= quo;
                        cnt    <= '0;
                        first  <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    step_pulse <= (cnt == '0);
                    step_level <= (cnt < (period >> 1));
                    if (cnt == '0) begin
                        step_idx  <= idx_next;
                        bar_pulse <= (idx_next == '0);
                        first     <= 1'b0;
                    end
                    if (wrap) begin
                        cnt <= '0;
                        if (pend) begin
                            period <= next_period;
                            pend   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the counter so a completion on a wrap edge defers to the next wrap.
            if (state == IDLE || restart) begin
                bpm_l <= bpm_c;
                dvs   <= PERIOD_W'(bpm_c);
                quo   <= NUM;
                rem   <= '0;
                it    <= '0;
                busy  <= 1'b1;
                pend  <= 1'b0;
            end else if (busy && !div_done) begin
                rem <= trial[PERIOD_W] ? shifted[PERIOD_W-1:0] : trial[PERIOD_W-1:0];
                quo <= {quo[PERIOD_W-2:0], ~trial[PERIOD_W]};
                it  <= it + 1'b1;
            end else if (busy) begin
                busy <= 1'b0;
                if (state == RUN) begin
                    next_period <= quo;
                    pend        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen at CLK_HZ=1600 (NUM=24000): step timing, clamping, tempo change, play drop, reset.
module tb_step_clock_gen;
    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       play = 1'b0;
    logic [7:0] bpm = 8'd120;
    logic       step_pulse;
    logic       step_level;
    logic [3:0] step_idx;
    logic       bar_pulse;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int cur_idx = 0;

    step_clock_gen #(.CLK_HZ(1600)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .play       (play),
        .bpm        (bpm),
        .step_pulse (step_pulse),
        .step_level (step_level),
        .step_idx   (step_idx),
        .bar_pulse  (bar_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int clampb(input int b);
        if (b < 40) return 40;
        if (b > 240) return 240;
        return b;
    endfunction

    function automatic int per(input int b);
        return 24000 / clampb(b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise play from IDLE; expects 33 busy clks, then the first pulse on the 35th sample.
    task automatic start(input int b);
        int pc;
        int bc;
        pc = 0;
        bc = 0;
        bpm  = 8'(b);
        play = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            pc += int'(step_pulse);
            bc += int'(busy);
        end
        chk("calc_pulses", 32'(pc), 32'd0);
        chk("calc_busy", 32'(bc), 32'd33);
        @(negedge clk);
        chk("first_pulse", 32'(step_pulse), 32'd1);
        chk("first_idx", 32'(step_idx), 32'd0);
        chk("first_bar", 32'(bar_pulse), 32'd1);
        cur_idx = 0;
    endtask

    // Entered on a sample showing a step pulse; step 0 lasts p0, the rest p1.
    task automatic run_steps(input int p0, input int p1, input int n, input int ca, input int ba,
                             input int cb, input int bb, input int exp_busy);
        int p;
        int bad;
        int pc;
        int bc;
        for (int s = 0; s < n; s++) begin
            p   = (s == 0) ? p0 : p1;
            bad = 0;
            pc  = 0;
            bc  = 0;
            for (int i = 0; i < p; i++) begin
                if (step_level !== (i < p / 2)) bad++;
                pc += int'(step_pulse);
                bc += int'(busy);
                if (s == 0 && i == ca) bpm = 8'(ba);
                if (s == 0 && i == cb) bpm = 8'(bb);
                @(negedge clk);
            end
            cur_idx = (cur_idx + 1) % 16;
            chk("level_shape", 32'(bad), 32'd0);
            chk("pulses_in_step", 32'(pc), 32'd1);
            chk("step_period", 32'(step_pulse), 32'd1);
            chk("step_idx", 32'(step_idx), 32'(cur_idx));
            chk("bar_pulse", 32'(bar_pulse), 32'(cur_idx == 0));
            if (s == 0) chk("busy_len", 32'(bc), 32'(exp_busy));
        end
    endtask

    task automatic stop(input int k);
        int q;
        for (int i = 0; i < k; i++) @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        chk("stop_pulse", 32'(step_pulse), 32'd0);
        chk("stop_idx", 32'(step_idx), 32'd0);
        chk("stop_level", 32'(step_level), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        q = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            q += int'(step_pulse) + int'(step_level) + int'(bar_pulse);
        end
        chk("idle_quiet", 32'(q), 32'd0);
    endtask

    initial begin
        int b;
        int b2;
        int ca;
        int cb;
        int pcur;
        int clamp_list[4];

        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_level", 32'(step_level), 32'd0);
        chk("rst_idx", 32'(step_idx), 32'd0);
        chk("rst_bar", 32'(bar_pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        nReset = 1'b1;
        @(negedge clk);

        // 120 bpm: 200-clk steps, a full bar plus one step.
        start(120);
        run_steps(200, 200, 17, -1, 0, -1, 0, 0);
        run_steps(200, 200, 6, -1, 0, -1, 0, 0);
        chk("at_idx7", 32'(step_idx), 32'd7);
        stop($urandom_range(1, 190));
        start(120);

        // 120 -> 240 sampled at cnt=20: old step keeps 200, then 100.
        run_steps(200, 100, 4, 19, 240, -1, 0, 33);
        pcur = 100;

        // Random tempo changes, some re-changed while the divider is busy.
        repeat (3) begin
            do b = $urandom_range(20, 250); while (clampb(b) == clampb(int'(bpm)));
            do b2 = $urandom_range(20, 250); while (clampb(b2) == clampb(b));
            ca = $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) begin
                cb = ca + $urandom_range(1, 20);
                run_steps(pcur, per(b2), 3, ca, b, cb, b2, cb - ca + 33);
                pcur = per(b2);
            end else begin
                run_steps(pcur, per(b), 3, ca, b, -1, 0, 33);
                pcur = per(b);
            end
        end

        // Clamping at both ends and at the boundary.
        clamp_list = '{10, 255, 40, 0};
        clamp_list[3] = $urandom_range(0, 255);
        foreach (clamp_list[j]) begin
            stop($urandom_range(0, 50));
            start(clamp_list[j]);
            run_steps(per(clamp_list[j]), per(clamp_list[j]), 2, -1, 0, -1, 0, 0);
            pcur = per(clamp_list[j]);
        end

        // play falls on the clk that would otherwise raise the next pulse.
        stop(pcur - 1);

        // Asynchronous reset in the middle of a step.
        b = $urandom_range(40, 240);
        start(b);
        repeat ($urandom_range(10, 90)) @(negedge clk);
        nReset = 1'b0;
        #1;
        chk("arst_pulse", 32'(step_pulse), 32'd0);
        chk("arst_level", 32'(step_level), 32'd0);
        chk("arst_idx", 32'(step_idx), 32'd0);
        chk("arst_bar", 32'(bar_pulse), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        play = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        start(120);
        run_steps(200, 200, 2, -1, 0, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
